// File: rtl/mips_arb_pkg.sv
// Shared types and widths for the dmem arbiter (CPU vs DMA port sharing).
package mips_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_CPU  = 2'd1,
        ARB_DMA  = 2'd2
    } arb_state_t;

    localparam int DMEM_AW = 32;
    localparam int DMEM_DW = 32;

    // Bits needed to hold 0..max inclusive.
    function automatic int cnt_w(input int max);
        return (max < 2) ? 1 : $clog2(max + 1);
    endfunction

endpackage

// File: rtl/dmem_arbiter_sat_counter.sv
// Saturating up-counter with clear; clear together with inc loads 1 (start of a new run).
module sat_counter
    import mips_arb_pkg::*;
#(
    parameter int MAX = 4,
    parameter int W   = cnt_w(MAX)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_d;
    logic [W-1:0] cnt_q;

    // NOTE: next-state defaults to the current value first, so no path leaves cnt_d unassigned (no latch).
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = inc ? W'(1) : '0;
        end else if (inc && (cnt_q < W'(MAX))) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // NOTE: state flops use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port dmem arbiter: CPU priority, bounded DMA bursts, starvation-forced DMA grant.
// Optional performance counters are enabled with `define DMEM_ARB_PERF_EN.
module dmem_arbiter
    import mips_arb_pkg::*;
#(
    parameter int MAX_BURST    = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cpu_req,
    input  logic               cpu_we,
    input  logic               cpu_sb,
    input  logic [DMEM_AW-1:0] cpu_adr,
    input  logic [DMEM_DW-1:0] cpu_wd,
    output logic               cpu_gnt,
    output logic               cpu_stall,
    output logic [DMEM_DW-1:0] cpu_rd,
    input  logic               dma_req,
    input  logic               dma_we,
    input  logic               dma_sb,
    input  logic [DMEM_AW-1:0] dma_adr,
    input  logic [DMEM_DW-1:0] dma_wd,
    output logic               dma_gnt,
    output logic [DMEM_DW-1:0] dma_rd,
    output logic               mem_we,
    output logic               mem_sb,
    output logic [DMEM_AW-1:0] mem_adr,
    output logic [DMEM_DW-1:0] mem_wd,
`ifdef DMEM_ARB_PERF_EN
    input  logic [DMEM_DW-1:0] mem_rd,
    input  logic               perf_clr,
    output logic [31:0]        cpu_stall_cnt,
    output logic [31:0]        dma_beat_cnt
`else
    input  logic [DMEM_DW-1:0] mem_rd
`endif
);

    localparam int BW = cnt_w(MAX_BURST);
    localparam int SW = cnt_w(STARVE_LIMIT);

    arb_state_t    st_d;
    arb_state_t    st_q;
    logic [BW-1:0] burst_cnt;
    logic [SW-1:0] starve_cnt;
    logic          starved;
    logic          burst_room;
    logic          burst_done;
    logic          cpu_pick;
    logic          dma_pick;

    // Grant is combinational from live requests and registered history; reset masks everything.
    always_comb begin
        starved    = (starve_cnt == SW'(STARVE_LIMIT));
        burst_room = (st_q == ARB_DMA) && (burst_cnt < BW'(MAX_BURST));
        burst_done = (st_q == ARB_DMA) && !burst_room;
        cpu_pick   = 1'b0;
        dma_pick   = 1'b0;
        if (reset) begin
            if (dma_req && burst_room) begin
                dma_pick = 1'b1;
            end else if (burst_done && cpu_req) begin
                cpu_pick = 1'b1;
            end else if (dma_req && starved) begin
                dma_pick = 1'b1;
            end else if (cpu_req) begin
                cpu_pick = 1'b1;
            end else if (dma_req) begin
                dma_pick = 1'b1;
            end
        end
        st_d = cpu_pick ? ARB_CPU : (dma_pick ? ARB_DMA : ARB_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            st_q <= ARB_IDLE;
        end else begin
            st_q <= st_d;
        end
    end

    // A DMA grant without burst room starts a fresh burst at 1.
    sat_counter #(.MAX(MAX_BURST), .W(BW)) u_burst (
        .clk   (clk),
        .reset (reset),
        .clr   (!dma_pick || !burst_room),
        .inc   (dma_pick),
        .cnt   (burst_cnt)
    );

    sat_counter #(.MAX(STARVE_LIMIT), .W(SW)) u_starve (
        .clk   (clk),
        .reset (reset),
        .clr   (!dma_req || dma_pick),
        .inc   (dma_req && !dma_pick),
        .cnt   (starve_cnt)
    );

    always_comb begin
        mem_we  = 1'b0;
        mem_sb  = 1'b0;
        mem_adr = '0;
        mem_wd  = '0;
        if (cpu_pick) begin
            mem_we  = cpu_we;
            mem_sb  = cpu_sb;
            mem_adr = cpu_adr;
            mem_wd  = cpu_wd;
        end else if (dma_pick) begin
            mem_we  = dma_we;
            mem_sb  = dma_sb;
            mem_adr = dma_adr;
            mem_wd  = dma_wd;
        end
    end

    assign cpu_gnt   = cpu_pick;
    assign dma_gnt   = dma_pick;
    assign cpu_stall = cpu_req && !cpu_pick;
    assign cpu_rd    = cpu_pick ? mem_rd : '0;
    assign dma_rd    = dma_pick ? mem_rd : '0;

`ifdef DMEM_ARB_PERF_EN
    logic [31:0] stall_cnt_d;
    logic [31:0] stall_cnt_q;
    logic [31:0] beat_cnt_d;
    logic [31:0] beat_cnt_q;

    // Clear dominates a coincident increment.
    always_comb begin
        stall_cnt_d = stall_cnt_q + {31'd0, cpu_stall};
        beat_cnt_d  = beat_cnt_q + {31'd0, dma_pick};
        if (perf_clr) begin
            stall_cnt_d = '0;
            beat_cnt_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt_q <= '0;
            beat_cnt_q  <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            beat_cnt_q  <= beat_cnt_d;
        end
    end

    assign cpu_stall_cnt = stall_cnt_q;
    assign dma_beat_cnt  = beat_cnt_q;
`endif

endmodule
